// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D memory-port arbiter: default widths,
// FSM state encoding and the IDLE-state arbitration rule.
package mem_arb_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t GNT_I = 2'd1;
  localparam arb_state_t GNT_D = 2'd2;

  // Choose the next grant from IDLE. A pending lock forces the D refill that
  // follows a write-back ahead of the I-side; otherwise conflicts alternate.
  function automatic arb_state_t pick_grant(input logic i_read,
                                            input logic d_read,
                                            input logic d_write,
                                            input logic lock,
                                            input logic last_d);
    logic d_req;
    d_req = d_read | d_write;
    if (lock && d_read)
      return GNT_D;
    else if (i_read && d_req)
      return last_d ? GNT_I : GNT_D;
    else if (i_read)
      return GNT_I;
    else if (d_req)
      return GNT_D;
    else
      return IDLE;
  endfunction

endpackage

// File: rtl/mem_req_mux.sv
// Combinational command steering: drives the memory command from the granted
// requester and returns mem_ready only to that requester.
module mem_req_mux #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
) (
  input  mem_arb_pkg::arb_state_t state,
  input  logic                    i_read,
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [ADDR_W-1:0]       d_addr,
  input  logic [DATA_W-1:0]       d_wdata,
  input  logic                    mem_ready,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    i_ready,
  output logic                    d_ready
);
  import mem_arb_pkg::*;

  // Select the command source; IDLE (and any illegal encoding) drives nothing.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    case (state)
      GNT_I: begin
        mem_read = i_read;
        mem_addr = i_addr;
        i_ready  = mem_ready;
      end
      GNT_D: begin
        // A write-back takes precedence if both D commands are raised.
        mem_write = d_write;
        mem_read  = d_read & ~d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_ready   = mem_ready;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the off-chip memory port between the I-cache miss
// path and the D-cache miss/write-back path. Round-robin on conflicts; a
// completed write-back locks the next grant for the D refill.
module mem_arbiter #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              grant_d
);
  import mem_arb_pkg::*;

  arb_state_t state_q, state_d;
  logic       lock_q, lock_d;
  logic       last_d_q, last_d_d;

  // Next-state, lock and round-robin history.
  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    last_d_d = last_d_q;
    case (state_q)
      IDLE: begin
        state_d = pick_grant(i_read, d_read, d_write, lock_q, last_d_q);
        if (state_d != IDLE) begin
          last_d_d = (state_d == GNT_D);
          lock_d   = 1'b0;
        end
      end
      GNT_I: begin
        // Completion or an abandoned request both release the port.
        if (mem_ready || !i_read)
          state_d = IDLE;
      end
      GNT_D: begin
        if (mem_ready) begin
          state_d = IDLE;
          if (d_write)
            lock_d = 1'b1;
        end else if (!(d_read || d_write)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers; reset drops any in-flight grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lock_q   <= 1'b0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      last_d_q <= last_d_d;
    end
  end

  assign busy    = (state_q == GNT_I) || (state_q == GNT_D);
  assign grant_d = (state_q == GNT_D);

  // Read data is broadcast; only the matching *_ready qualifies it.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  mem_req_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .state     (state_q),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .mem_ready (mem_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .i_ready   (i_ready),
    .d_ready   (d_ready)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed arbitration scenarios followed by random
// traffic, all checked against a transaction-level ownership model.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_read, d_read, d_write, mem_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          i_ready, d_ready, mem_read, mem_write, busy, grant_d;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, i_rdata, d_rdata;

  int total = 0;
  int bad   = 0;

  // Model: who owns the memory port (0 nobody, 1 I-cache, 2 D-cache)
  int own    = 0;
  bit m_lock = 1'b0;
  bit m_last = 1'b0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    own    = 0;
    m_lock = 1'b0;
    m_last = 1'b0;
  endtask

  // Advance ownership by one clock edge using the request/ready lines seen there.
  task automatic model_step();
    int pick;
    pick = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (own == 0) begin
      if (m_lock && d_read)                  pick = 2;
      else if (i_read && (d_read || d_write)) pick = m_last ? 1 : 2;
      else if (i_read)                       pick = 1;
      else if (d_read || d_write)            pick = 2;
      if (pick != 0) begin
        m_last = (pick == 2);
        m_lock = 1'b0;
      end
      own = pick;
    end else if (own == 1) begin
      if (mem_ready || !i_read) own = 0;
    end else begin
      if (mem_ready) begin
        if (d_write) m_lock = 1'b1;
        own = 0;
      end else if (!(d_read || d_write)) begin
        own = 0;
      end
    end
  endtask

  task automatic check_all();
    logic          e_mr, e_mw;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_wd;
    e_mr = 1'b0; e_mw = 1'b0; e_a = '0; e_wd = '0;
    if (own == 1) begin
      e_mr = i_read;
      e_a  = i_addr;
    end else if (own == 2) begin
      e_mw = d_write;
      e_mr = d_read && !d_write;
      e_a  = d_addr;
      e_wd = d_wdata;
    end
    chk("mem_read",  mem_read,  e_mr);
    chk("mem_write", mem_write, e_mw);
    chk("mem_addr",  mem_addr,  e_a);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("i_ready",   i_ready,   mem_ready && own == 1);
    chk("d_ready",   d_ready,   mem_ready && own == 2);
    chk("busy",      busy,      own != 0);
    chk("grant_d",   grant_d,   own == 2);
    chk("i_rdata",   i_rdata,   mem_rdata);
    chk("d_rdata",   d_rdata,   mem_rdata);
  endtask

  // One cycle: check mid-cycle, step the model at the edge, return at edge+1.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic clear_reqs();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_ready = 1'b0;
  endtask

  // Assert reset asynchronously mid-cycle, hold it over one edge, release.
  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_busy",    busy,      1'b0);
    chk("rst_grant_d", grant_d,   1'b0);
    chk("rst_mem_rd",  mem_read,  1'b0);
    chk("rst_mem_wr",  mem_write, 1'b0);
    chk("rst_mem_adr", mem_addr,  '0);
    chk("rst_d_ready", d_ready,   1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_reqs();
    i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_rdata = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    mem_ready = 1'b1;
    #3;
    chk("reset_busy",    busy,      1'b0);
    chk("reset_grant_d", grant_d,   1'b0);
    chk("reset_mem_rd",  mem_read,  1'b0);
    chk("reset_mem_wr",  mem_write, 1'b0);
    chk("reset_i_ready", i_ready,   1'b0);
    chk("reset_d_ready", d_ready,   1'b0);
    chk("reset_i_rdata", i_rdata,   mem_rdata);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b0;

    // Conflict after reset: D first, then I, then D again on a second conflict
    i_read = 1'b1; i_addr = 28'h0000100; d_read = 1'b1; d_addr = 28'h0000200;
    tick();
    #2; chk("c1_grant_d", grant_d, 1'b1); chk("c1_addr", mem_addr, 28'h0000200);
    mem_ready = 1'b1;
    #1; chk("c1_d_ready", d_ready, 1'b1); chk("c1_i_ready", i_ready, 1'b0);
    tick();
    d_read = 1'b0; mem_ready = 1'b0;
    #2; chk("c1_gap_idle", busy, 1'b0);
    tick();
    #2; chk("c1_i_grant", busy & ~grant_d, 1'b1); chk("c1_i_addr", mem_addr, 28'h0000100);
    mem_ready = 1'b1;
    tick();
    i_read = 1'b0; mem_ready = 1'b0;
    tick();
    i_read = 1'b1; d_read = 1'b1;
    tick();
    #2; chk("c2_grant_d", grant_d, 1'b1);
    mem_ready = 1'b1;
    tick();
    clear_reqs();
    tick();

    // Single I request, memory ready on the 4th granted cycle
    i_read = 1'b1; i_addr = 28'h0000010;
    #2; chk("s1_idle_rd", mem_read, 1'b0);
    tick();
    #2; chk("s1_mem_rd", mem_read, 1'b1); chk("s1_addr", mem_addr, 28'h0000010);
    tick(); tick(); tick();
    mem_ready = 1'b1;
    #2; chk("s1_i_ready", i_ready, 1'b1); chk("s1_d_ready", d_ready, 1'b0);
    tick();
    i_read = 1'b0; mem_ready = 1'b0;
    #2; chk("s1_idle_after", busy, 1'b0);
    tick();

    // Dirty miss with i_read held throughout; start from a fresh history
    pulse_reset();
    i_read = 1'b1; i_addr = 28'h0000300;
    d_write = 1'b1; d_addr = 28'h0000020; d_wdata = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    tick();
    #2; chk("dm_wr", mem_write, 1'b1); chk("dm_wr_addr", mem_addr, 28'h0000020);
    chk("dm_wdata", mem_wdata, 128'hdead_beef_0000_1111_2222_3333_4444_5555);
    mem_ready = 1'b1;
    tick();
    d_write = 1'b0; d_read = 1'b1; d_addr = 28'h0000040; mem_ready = 1'b0;
    tick();
    #2; chk("dm_lock_gnt", grant_d, 1'b1); chk("dm_rd_addr", mem_addr, 28'h0000040);
    mem_ready = 1'b1;
    tick();
    d_read = 1'b0; mem_ready = 1'b0;
    tick();
    #2; chk("dm_i_next", busy & ~grant_d, 1'b1);
    mem_ready = 1'b1;
    tick();
    clear_reqs();
    tick();

    // d_read and d_write together: write wins and the lock is armed
    d_read = 1'b1; d_write = 1'b1; d_addr = 28'h0000060;
    tick();
    #2; chk("rw_mem_wr", mem_write, 1'b1); chk("rw_mem_rd", mem_read, 1'b0);
    mem_ready = 1'b1;
    tick();
    d_write = 1'b0; i_read = 1'b1; mem_ready = 1'b0;
    tick();
    #2; chk("rw_lock_gnt", grant_d, 1'b1);
    mem_ready = 1'b1;
    tick();
    clear_reqs();
    tick();

    // Abandoned I request and a stray mem_ready in IDLE
    i_read = 1'b1; i_addr = 28'h0000777;
    tick();
    tick();
    i_read = 1'b0;
    #2; chk("ab_rd_drop", mem_read, 1'b0);
    tick();
    #2; chk("ab_idle", busy, 1'b0);
    mem_ready = 1'b1;
    #1; chk("ab_stray_i", i_ready, 1'b0); chk("ab_stray_d", d_ready, 1'b0);
    tick();
    mem_ready = 1'b0;
    tick();

    // Reset in the middle of a D grant, then fresh arbitration
    d_read = 1'b1; d_addr = 28'h0000055;
    tick();
    #2; chk("rm_mem_rd", mem_read, 1'b1);
    pulse_reset();
    tick();
    #2; chk("rm_regrant", grant_d, 1'b1); chk("rm_addr", mem_addr, 28'h0000055);
    mem_ready = 1'b1;
    tick();
    clear_reqs();
    tick();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      i_read    = ($urandom_range(0, 9) < 6);
      d_read    = ($urandom_range(0, 9) < 4);
      d_write   = ($urandom_range(0, 9) < 2);
      mem_ready = ($urandom_range(0, 3) == 0);
      i_addr    = AW'($urandom);
      d_addr    = AW'($urandom);
      d_wdata   = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
